mic_tdoa_xcorr: RTL and testbench



---
 rtl/mic_xcorr_pkg.sv | 29 ++
 rtl/mic_tdoa_xcorr_if.sv | 36 +++
 rtl/mic_delay_line.sv | 32 +++
 rtl/mic_tdoa_xcorr.sv | 163 ++++++++++++++++
 tb/tb_mic_tdoa_xcorr.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mic_xcorr_pkg.sv
// Shared definitions for the microphone TDOA cross-correlator.
// Holds the FSM state type, the default geometry and the width derivations
// used by the interface and the datapath. Nothing here has ports.
package mic_xcorr_pkg;

  localparam int MAX_LAG_DEF   = 8;    // largest lag magnitude, samples
  localparam int FRAME_LEN_DEF = 256;  // samples per correlation frame
  localparam int DATA_W_DEF    = 16;   // bits kept from each 24-bit sample
  localparam int SAMPLE_W      = 24;   // I2S capture word width

  typedef enum logic [2:0] {
    IDLE,  // disabled, everything held clear
    WAIT,  // waiting for the next sample strobe
    MAC,   // one lag accumulated per clock
    SCAN,  // one lag compared per clock
    DONE   // publish result, restart the frame
  } state_e;

  // Signed lag range is -MAX_LAG..+MAX_LAG.
  function automatic int lag_w(input int max_lag);
    return $clog2(max_lag + 1) + 1;
  endfunction

  // Full product plus enough headroom to sum a whole frame without overflow.
  function automatic int acc_w(input int data_w, input int frame_len);
    return 2 * data_w + $clog2(frame_len);
  endfunction

endpackage

// File: rtl/mic_tdoa_xcorr_if.sv
// Capture-to-correlator bundle.
//   master (capture side): drives en, sample_valid, ch_a, ch_b; reads results.
//   slave  (correlator)  : reads the sample pair; drives lag_out, peak_out,
//                          lag_valid, busy, overrun.
interface mic_tdoa_xcorr_if
  import mic_xcorr_pkg::*;
#(
  parameter int MAX_LAG   = MAX_LAG_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DATA_W    = DATA_W_DEF
) ();

  localparam int LAG_W = lag_w(MAX_LAG);
  localparam int ACC_W = acc_w(DATA_W, FRAME_LEN);

  logic                       en;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] ch_a;
  logic signed [SAMPLE_W-1:0] ch_b;
  logic signed [LAG_W-1:0]    lag_out;
  logic signed [ACC_W-1:0]    peak_out;
  logic                       lag_valid;
  logic                       busy;
  logic                       overrun;

  modport master (
    output en, sample_valid, ch_a, ch_b,
    input  lag_out, peak_out, lag_valid, busy, overrun
  );

  modport slave (
    input  en, sample_valid, ch_a, ch_b,
    output lag_out, peak_out, lag_valid, busy, overrun
  );

endinterface

// File: rtl/mic_delay_line.sv
// Shift-register delay line with every stage exposed.
//   clk, rst_dsp : clock, asynchronous active-low reset
//   shift_en     : push din into taps[0], older samples move up one stage
//   clear        : synchronous zero of all stages (wins over shift_en)
//   din          : new sample
//   taps[i]      : sample delayed by i shifts
module mic_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_dsp,
  input  logic                    shift_en,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] taps [DEPTH]
);

  // NOTE: sequential state is written with <= so every stage samples the
  // previous stage's pre-edge value; = here would collapse the chain.
  always_ff @(posedge clk or negedge rst_dsp) begin
    if (!rst_dsp) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

endmodule

// File: rtl/mic_tdoa_xcorr.sv
// Time-difference-of-arrival estimator for one microphone pair.
// Each accepted sample updates 2*MAX_LAG+1 cross-correlation accumulators,
// one per clock through a single multiplier; after FRAME_LEN samples the
// accumulators are scanned and the lag of the largest one is reported.
//   clk, rst_dsp : clock, asynchronous active-low reset
//   bus (slave)  : en, sample_valid, ch_a, ch_b in;
//                  lag_out (positive = ch_b lags ch_a), peak_out,
//                  lag_valid (1-cycle), busy, overrun (sticky) out
module mic_tdoa_xcorr
  import mic_xcorr_pkg::*;
#(
  parameter int MAX_LAG   = MAX_LAG_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic clk,
  input  logic rst_dsp,
  mic_tdoa_xcorr_if.slave bus
);

  localparam int LAG_W  = lag_w(MAX_LAG);
  localparam int ACC_W  = acc_w(DATA_W, FRAME_LEN);
  localparam int NK     = 2 * MAX_LAG + 1;
  localparam int K_W    = $clog2(NK);
  localparam int CNT_W  = $clog2(FRAME_LEN) + 1;
  localparam int PROD_W = 2 * DATA_W;

  state_e                  state;
  logic [K_W-1:0]          k;
  logic [CNT_W-1:0]        count;
  logic signed [ACC_W-1:0] acc [NK];
  logic signed [ACC_W-1:0] best_acc;
  logic [K_W-1:0]          best_k;

  logic signed [LAG_W-1:0] lag_q;
  logic signed [ACC_W-1:0] peak_q;
  logic                    lag_valid_q;
  logic                    busy_q;
  logic                    overrun_q;

  // Keep the MSBs; the low bits of the capture word are below the noise floor.
  logic signed [DATA_W-1:0] a_in, b_in;
  assign a_in = bus.ch_a[SAMPLE_W-1 -: DATA_W];
  assign b_in = bus.ch_b[SAMPLE_W-1 -: DATA_W];

  logic unused_low_bits;
  assign unused_low_bits = ^{bus.ch_a[SAMPLE_W-DATA_W-1:0], bus.ch_b[SAMPLE_W-DATA_W-1:0]};

  // Samples are taken only from WAIT, so a strobe while busy (or on the
  // enable edge, when still in IDLE) never disturbs the history.
  logic shift_en, dl_clear;
  assign shift_en = bus.en && bus.sample_valid && (state == WAIT);
  assign dl_clear = !bus.en;

  logic signed [DATA_W-1:0] a_taps [MAX_LAG+1];
  logic signed [DATA_W-1:0] b_taps [NK];

  mic_delay_line #(.DEPTH(MAX_LAG + 1), .WIDTH(DATA_W)) u_dl_a (
    .clk(clk), .rst_dsp(rst_dsp), .shift_en(shift_en), .clear(dl_clear),
    .din(a_in), .taps(a_taps)
  );

  mic_delay_line #(.DEPTH(NK), .WIDTH(DATA_W)) u_dl_b (
    .clk(clk), .rst_dsp(rst_dsp), .shift_en(shift_en), .clear(dl_clear),
    .din(b_in), .taps(b_taps)
  );

  // Centre-delayed A against every B tap: acc[k] ends up holding lag MAX_LAG-k.
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  assign prod     = a_taps[MAX_LAG] * b_taps[k];
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst_dsp) begin
    if (!rst_dsp) begin
      state       <= IDLE;
      k           <= '0;
      count       <= '0;
      best_acc    <= '0;
      best_k      <= '0;
      lag_q       <= '0;
      peak_q      <= '0;
      lag_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      // NOTE: the accumulator bank is a handful of registers, not a RAM, and
      // must read zero out of reset, so it takes the async reset like any flop.
      for (int i = 0; i < NK; i++) acc[i] <= '0;
    end else if (!bus.en) begin
      state       <= IDLE;
      k           <= '0;
      count       <= '0;
      lag_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NK; i++) acc[i] <= '0;
    end else begin
      lag_valid_q <= 1'b0;
      if (bus.sample_valid && busy_q) overrun_q <= 1'b1;

      case (state)
        IDLE: state <= WAIT;

        WAIT: begin
          if (bus.sample_valid) begin
            state  <= MAC;
            k      <= '0;
            busy_q <= 1'b1;
          end
        end

        MAC: begin
          acc[k] <= acc[k] + prod_ext;
          if (k == K_W'(NK - 1)) begin
            k     <= '0;
            count <= count + 1'b1;
            if (count == CNT_W'(FRAME_LEN - 1)) begin
              state <= SCAN;
            end else begin
              state  <= WAIT;
              busy_q <= 1'b0;
            end
          end else begin
            k <= k + 1'b1;
          end
        end

        SCAN: begin
          // Strict compare: ties keep the lowest k, i.e. the most positive lag.
          if (k == '0 || acc[k] > best_acc) begin
            best_acc <= acc[k];
            best_k   <= k;
          end
          if (k == K_W'(NK - 1)) begin
            k     <= '0;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end

        DONE: begin
          lag_q       <= LAG_W'(MAX_LAG - int'(best_k));
          peak_q      <= best_acc;
          lag_valid_q <= 1'b1;
          count       <= '0;
          busy_q      <= 1'b0;
          state       <= WAIT;
          for (int i = 0; i < NK; i++) acc[i] <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lag_out   = lag_q;
  assign bus.peak_out  = peak_q;
  assign bus.lag_valid = lag_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_mic_tdoa_xcorr.sv
// Directed-sequence bench for mic_tdoa_xcorr with a history-based
// cross-correlation reference model.
module tb_mic_tdoa_xcorr;
  import mic_xcorr_pkg::*;

  localparam int M   = 8;
  localparam int N   = 256;
  localparam int DW  = 16;
  localparam int NK  = 2 * M + 1;
  localparam int GAP = 40;          // strobe spacing, above the lossless minimum
  localparam int LAT = 4 * M + 4;   // strobe cycle to lag_valid cycle

  logic clk = 1'b0;
  logic rst_dsp = 1'b0;
  always #5 clk = ~clk;

  mic_tdoa_xcorr_if #(.MAX_LAG(M), .FRAME_LEN(N), .DATA_W(DW)) bus ();

  mic_tdoa_xcorr #(.MAX_LAG(M), .FRAME_LEN(N), .DATA_W(DW)) dut (
    .clk(clk),
    .rst_dsp(rst_dsp),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: remembers every lag_valid pulse and when it happened.
  int lv_count = 0;
  int lv_cyc = 0;
  logic signed [63:0] lv_lag = '0;
  logic signed [63:0] lv_peak = '0;
  always @(negedge clk) begin
    if (bus.lag_valid === 1'b1) begin
      lv_count++;
      lv_cyc  = cyc;
      lv_lag  = bus.lag_out;
      lv_peak = bus.peak_out;
    end
  end

  // Reference model: every accepted (truncated) sample since enable.
  int      qa[$];
  int      qb[$];
  int      frame_start = 0;
  int      frame_cnt = 0;
  int      exp_frames = 0;
  int      exp_lag = 0;
  longint  exp_peak = 0;
  int      strobe_cyc = 0;
  logic [23:0] xs [N];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Keeping the top 16 of 24 bits is a floor division by 256.
  function automatic int trunc24(input logic [23:0] v);
    int t;
    t = int'($signed(v));
    return t >>> 8;
  endfunction

  function automatic logic [23:0] rnd24();
    logic [31:0] r;
    r = $urandom();
    return r[23:0];
  endfunction

  task automatic model_clear();
    qa.delete();
    qb.delete();
    frame_start = 0;
    frame_cnt   = 0;
  endtask

  // corr(lag) over the frame = sum of a[n-M] * b[n-k], lag = M-k, with zeros
  // before the first sample since enable; winner is the first strict maximum.
  task automatic model_push(input logic [23:0] a, input logic [23:0] b);
    longint s, best;
    int bk;
    best = 0;
    bk = 0;
    qa.push_back(trunc24(a));
    qb.push_back(trunc24(b));
    frame_cnt++;
    if (frame_cnt == N) begin
      for (int kk = 0; kk < NK; kk++) begin
        s = 0;
        for (int n = frame_start; n < qa.size(); n++)
          if (n - M >= 0 && n - kk >= 0)
            s += longint'(qa[n-M]) * longint'(qb[n-kk]);
        if (kk == 0 || s > best) begin
          best = s;
          bk = kk;
        end
      end
      exp_peak    = best;
      exp_lag     = M - bk;
      exp_frames++;
      frame_start = qa.size();
      frame_cnt   = 0;
    end
  endtask

  // Called at a negedge; one-cycle strobe, then idles until gap cycles elapse.
  task automatic put(input logic [23:0] a, input logic [23:0] b,
                     input int gap, input bit accept);
    bus.ch_a = a;
    bus.ch_b = b;
    bus.sample_valid = 1'b1;
    strobe_cyc = cyc;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    if (accept) model_push(a, b);
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_frames"}, lv_count, exp_frames);
    check({tag, "_lag"}, lv_lag, exp_lag);
    check({tag, "_peak"}, lv_peak, exp_peak);
    check({tag, "_latency"}, lv_cyc - strobe_cyc, LAT);
  endtask

  initial begin
    logic [23:0] a, b;
    bus.en = 1'b0;
    bus.sample_valid = 1'b0;
    bus.ch_a = '0;
    bus.ch_b = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_lag", bus.lag_out, 0);
    check("rst_peak", bus.peak_out, 0);
    check("rst_lag_valid", bus.lag_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    rst_dsp = 1'b1;
    @(negedge clk);
    bus.en = 1'b1;
    repeat (2) @(negedge clk);

    // Impulse: ch_b repeats ch_a three samples later.
    for (int i = 0; i < N; i++) begin
      a = (i == 50) ? 24'd256000 : 24'd0;
      b = (i == 53) ? 24'd256000 : 24'd0;
      put(a, b, GAP, 1'b1);
    end
    check_frame("impulse");
    check("impulse_lag_abs", lv_lag, 3);
    check("impulse_peak_abs", lv_peak, 1000000);

    // Reverse delay on random data, with an overrun planted at sample 20.
    for (int i = 0; i < N; i++) begin
      xs[i] = rnd24();
      a = (i >= 5) ? xs[i-5] : 24'd0;
      b = xs[i];
      if (i == 20) begin
        put(a, b, 10, 1'b1);
        check("ovr_busy", bus.busy, 1);
        check("ovr_before", bus.overrun, 0);
        put(rnd24(), rnd24(), GAP - 10, 1'b0);
        check("ovr_set", bus.overrun, 1);
      end else begin
        put(a, b, GAP, 1'b1);
      end
    end
    check_frame("reverse");
    check("reverse_lag_abs", lv_lag, -5);
    check("ovr_sticky", bus.overrun, 1);

    // Tie: fresh enable, both channels at the most negative code.
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    check("dis_overrun", bus.overrun, 0);
    check("dis_busy", bus.busy, 0);
    model_clear();
    bus.en = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) put(24'h800000, 24'h800000, GAP, 1'b1);
    check_frame("tie");
    check("tie_lag_abs", lv_lag, 8);

    // Extremes: full history of 0x800000, every product 2^30.
    for (int i = 0; i < N; i++) put(24'h800000, 24'h800000, GAP, 1'b1);
    check_frame("extreme");
    check("extreme_peak_abs", lv_peak, longint'(1) << 38);
    check("extreme_lag_abs", lv_lag, 8);

    // Abort after 100 samples, with an overrun to be cleared by en low.
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        put(rnd24(), rnd24(), 10, 1'b1);
        put(rnd24(), rnd24(), GAP - 10, 1'b0);
      end else begin
        put(rnd24(), rnd24(), GAP, 1'b1);
      end
    end
    check("abort_ovr_set", bus.overrun, 1);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_ovr_clr", bus.overrun, 0);
    check("abort_no_lv", lv_count, exp_frames);
    model_clear();

    // Strobe on the enable edge is ignored.
    bus.en = 1'b1;
    bus.ch_a = rnd24();
    bus.ch_b = rnd24();
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    check("enrise_ignored", bus.busy, 0);
    repeat (GAP) @(negedge clk);
    for (int i = 0; i < N - 1; i++) put(rnd24(), rnd24(), GAP, 1'b1);
    check("reenable_255_no_lv", lv_count, exp_frames);
    put(rnd24(), rnd24(), GAP, 1'b1);
    check_frame("reenable");

    // Reset in the middle of MAC, with overrun set.
    bus.ch_a = rnd24();
    bus.ch_b = rnd24();
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    check("midmac_overrun", bus.overrun, 1);
    #2 rst_dsp = 1'b0;
    #1;
    check("midrst_lag", bus.lag_out, 0);
    check("midrst_peak", bus.peak_out, 0);
    check("midrst_lag_valid", bus.lag_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_overrun", bus.overrun, 0);
    @(negedge clk);
    rst_dsp = 1'b1;
    model_clear();
    @(negedge clk);
    for (int i = 0; i < N; i++) put(rnd24(), rnd24(), GAP, 1'b1);
    check_frame("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
